// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared types and helpers for the reset sequencer
// and its fractional clock-enable channels.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int hold_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_rst_seq_frac_ce.sv
// frac_ce: exact-ratio NUM/DEN clock-enable strobe generator.
// Accumulates NUM each enabled cycle and emits a strobe on wrap.
module frac_ce #(
  parameter int NUM = 1,
  parameter int DEN = 8,
  parameter int W   = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic en,
  input  logic freeze,
  output logic ce
);

  if (!(NUM > 0 && NUM <= DEN &&
        longint'(DEN) < (longint'(1) << W))) begin : g_bad_ratio
    $error("frac_ce: need 0 < NUM <= DEN < 2**W");
  end

  localparam logic [W:0] NUM_C = (W+1)'(NUM);
  localparam logic [W:0] DEN_C = (W+1)'(DEN);

  logic [W:0] acc_q;
  logic [W:0] acc_d;
  logic [W:0] sum;
  logic       ce_q;
  logic       ce_d;

  // Next accumulator phase; cleared when disabled, held when frozen.
  always_comb begin
    sum   = acc_q + NUM_C;
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (!en) begin
      acc_d = '0;
    end else if (!freeze) begin
      if (sum >= DEN_C) begin
        acc_d = sum - DEN_C;
        ce_d  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Accumulator and registered strobe.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL-lock reset sequencer with CPU and pixel
// fractional clock enables on clk_sys.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int CE_W        = 16,
  parameter int NUM0        = 1,
  parameter int DEN0        = 8,
  parameter int NUM1        = 7,
  parameter int DEN1        = 96
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic pause,
  output logic core_rst_n,
  output logic ce_cpu,
  output logic ce_pix,
  output logic lock_lost
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("clk_rst_seq: HOLD_CYCLES must be >= 1");
  end

  localparam int CW = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  seq_state_t             state_q;
  seq_state_t             state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   core_rst_n_q;
  logic                   lock_lost_q;
  logic                   lock_lost_d;
  logic                   ce_en;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock loss overrides everything; otherwise walk WAIT->HOLD->RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!locked_s) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign lock_lost_d = lock_lost_q |
    ((state_q == ST_RUN) &&
     (state_d == ST_WAIT_LOCK));

  // Enables only count while staying in RUN, so the
  // lock-loss edge also kills any strobe in flight.
  assign ce_en = (state_q == ST_RUN) &&
                 (state_d == ST_RUN);

  // Synchroniser, FSM, hold counter and status registers.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= (state_d == ST_RUN);
      lock_lost_q  <= lock_lost_d;
    end
  end

  frac_ce #(
    .NUM (NUM0),
    .DEN (DEN0),
    .W   (CE_W)
  ) u_ce_cpu (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (ce_en),
    .freeze  (pause),
    .ce      (ce_cpu)
  );

  frac_ce #(
    .NUM (NUM1),
    .DEN (DEN1),
    .W   (CE_W)
  ) u_ce_pix (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (ce_en),
    .freeze  (pause),
    .ce      (ce_pix)
  );

  assign core_rst_n = core_rst_n_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed bench for the reset sequencer
// and its fractional clock enables.
module tb_clk_rst_seq;

  logic clk = 1'b0;
  logic rst_n, pll_locked, pause;
  logic core_rst_n, ce_cpu, ce_pix, lock_lost;
  logic rst_n_e, lock_e, pause_e;
  logic core_e, cpu_e, pix_e, lost_e;

  int n_pass  = 0;
  int n_total = 0;
  int ph      = 0;

  always #5 clk = ~clk;

  clk_rst_seq #(.HOLD_CYCLES(16)) dut (
    .clk_sys    (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pause      (pause),
    .core_rst_n (core_rst_n),
    .ce_cpu     (ce_cpu),
    .ce_pix     (ce_pix),
    .lock_lost  (lock_lost)
  );

  clk_rst_seq #(
    .HOLD_CYCLES (1),
    .NUM0        (5),
    .DEN0        (5)
  ) dut_e (
    .clk_sys    (clk),
    .rst_n      (rst_n_e),
    .pll_locked (lock_e),
    .pause      (pause_e),
    .core_rst_n (core_e),
    .ce_cpu     (cpu_e),
    .ce_pix     (pix_e),
    .lock_lost  (lost_e)
  );

  function automatic logic strobe(input int i, input int n, input int d);
    if (i <= 0) return 1'b0;
    return ((i * n) / d) != (((i - 1) * n) / d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_run(input logic p);
    pause = p;
    tick();
    if (!p) ph++;
    chk("ce_cpu_seq", ce_cpu, p ? 1'b0 : strobe(ph, 1, 8));
    chk("ce_pix_seq", ce_pix, p ? 1'b0 : strobe(ph, 7, 96));
  endtask

  task automatic wait_release(input string tag);
    int early = 0;
    repeat (18) begin
      tick();
      if (core_rst_n !== 1'b0 || ce_cpu !== 1'b0 || ce_pix !== 1'b0)
        early++;
    end
    chk({tag, "_early"}, early, 0);
    tick();
    chk({tag, "_rise"}, core_rst_n, 1);
    chk({tag, "_cpu0"}, ce_cpu, 0);
    chk({tag, "_pix0"}, ce_pix, 0);
    ph = 0;
  endtask

  initial begin
    int nc, np, firstp, lastp, badgap, early;
    rst_n = 1'b0; pll_locked = 1'b1; pause = 1'b0;
    rst_n_e = 1'b0; lock_e = 1'b1; pause_e = 1'b0;

    repeat (4) tick();
    chk("rst_core", core_rst_n, 0);
    chk("rst_cpu", ce_cpu, 0);
    chk("rst_pix", ce_pix, 0);
    chk("rst_lost", lock_lost, 0);

    rst_n = 1'b1;
    wait_release("pwr");

    nc = 0; np = 0; firstp = -1; lastp = -1; badgap = 0;
    repeat (960) begin
      step_run(1'b0);
      if (ce_cpu) nc++;
      if (ce_pix) begin
        np++;
        if (firstp < 0) firstp = ph;
        else if (ph - lastp != 13 && ph - lastp != 14) badgap++;
        lastp = ph;
      end
    end
    chk("ratio_cpu", nc, 120);
    chk("ratio_pix", np, 70);
    chk("first_pix", firstp, 14);
    chk("pix_gaps", badgap, 0);

    repeat (37) step_run(1'b1);
    repeat (100) step_run(1'b0);
    chk("pause_core", core_rst_n, 1);

    pll_locked = 1'b0;
    step_run(1'b0);
    step_run(1'b0);
    chk("drop_lost_pre", lock_lost, 0);
    chk("drop_core_pre", core_rst_n, 1);
    tick();
    chk("drop_core", core_rst_n, 0);
    chk("drop_cpu", ce_cpu, 0);
    chk("drop_pix", ce_pix, 0);
    chk("drop_lost", lock_lost, 1);
    repeat (5) tick();
    chk("drop_lost_hold", lock_lost, 1);
    pll_locked = 1'b1;
    wait_release("relock");
    chk("relock_lost", lock_lost, 1);
    repeat (20) step_run(1'b0);

    rst_n = 1'b0;
    tick();
    chk("rst2_core", core_rst_n, 0);
    tick();
    chk("rst2_lost", lock_lost, 0);
    rst_n = 1'b1;
    repeat (13) tick();
    chk("hold10_core", core_rst_n, 0);
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_release("glitch");
    chk("glitch_lost", lock_lost, 0);
    repeat (12) step_run(1'b0);

    rst_n_e = 1'b1;
    early = 0;
    repeat (3) begin
      tick();
      if (core_e !== 1'b0 || cpu_e !== 1'b0) early++;
    end
    chk("e_early", early, 0);
    tick();
    chk("e_core", core_e, 1);
    chk("e_cpu_idx0", cpu_e, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("e_cpu_full", cpu_e, 1);
    end
    rst_n_e = 1'b0;
    tick();
    chk("e_rst_core", core_e, 0);
    chk("e_rst_cpu", cpu_e, 0);
    chk("e_rst_pix", pix_e, 0);
    chk("e_rst_lost", lost_e, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
